ahb2apb_bridge: RTL and testbench

Parametrised AHB-Lite slave to APB4 master bridge. It converts each AHB transfer into one APB SETUP/ACCESS sequence on one of NUM_SLV decoded APB slaves, and returns read data and OKAY/ERROR responses to the AHB master. It is the synthesisable core that sits between the AHB agent and the APB peripherals.

---
 rtl/ahb2apb_pkg.sv | 38 +++
 rtl/ahb2apb_bridge_apb_slv_mux.sv | 33 +++
 rtl/ahb2apb_bridge.sv | 154 +++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared types and helpers for the AHB-Lite to APB4 bridge.
package ahb2apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Slave index field is wide enough for 16 slaves so out-of-range indices are visible.
    localparam int unsigned SEL_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    function automatic logic [7:0] strb_gen(input logic [2:0] hsize, input logic [2:0] addr_lsbs);
        logic [7:0] ones;
        case (hsize)
            3'd0:    ones = 8'h01;
            3'd1:    ones = 8'h03;
            3'd2:    ones = 8'h0F;
            default: ones = 8'hFF;
        endcase
        return ones << addr_lsbs;
    endfunction

endpackage

// File: rtl/ahb2apb_bridge_apb_slv_mux.sv
// APB slave index decode and read-data/ready/error return mux.
module apb_slv_mux
    import ahb2apb_pkg::*;
#(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned AHB_DW  = 32
) (
    input  logic [SEL_W-1:0]          idx_i,
    input  logic [NUM_SLV*AHB_DW-1:0] prdata_i,
    input  logic [NUM_SLV-1:0]        pready_i,
    input  logic [NUM_SLV-1:0]        pslverr_i,
    output logic [NUM_SLV-1:0]        sel_o,
    output logic [AHB_DW-1:0]         prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o
);

    always_comb begin
        sel_o     = '0;
        prdata_o  = '0;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (32'(idx_i) == i) begin
                sel_o[i]  = 1'b1;
                prdata_o  = prdata_i[i*AHB_DW +: AHB_DW];
                pready_o  = pready_i[i];
                pslverr_o = pslverr_i[i];
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge, one APB SETUP/ACCESS per AHB transfer.
// Define AHB2APB_TIMEOUT_EN to abort ACCESS with an ERROR after TIMEOUT_CYC cycles.
module ahb2apb_bridge
    import ahb2apb_pkg::*;
#(
    parameter int unsigned AHB_AW      = 32,
    parameter int unsigned AHB_DW      = 32,
    parameter int unsigned NUM_SLV     = 4,
    parameter int unsigned SLV_SEL_LSB = 12,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hsel,
    input  logic [AHB_AW-1:0]         haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [AHB_DW-1:0]         hwdata,
    input  logic                      hready,
    output logic                      hreadyout,
    output logic [AHB_DW-1:0]         hrdata,
    output logic                      hresp,
    output logic [AHB_AW-1:0]         paddr,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [AHB_DW-1:0]         pwdata,
    output logic [AHB_DW/8-1:0]       pstrb,
    input  logic [NUM_SLV*AHB_DW-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int unsigned STRBW = AHB_DW / 8;
    localparam int unsigned LSBW  = $clog2(STRBW);

    state_t             state_q, state_d;
    logic [AHB_AW-1:0]  addr_q;
    logic               write_q;
    logic [2:0]         size_q;
    logic [AHB_DW-1:0]  wdata_q;
    logic [AHB_DW-1:0]  rdata_q;
    logic [STRBW-1:0]   strb_q;

    logic               accept;
    logic               req_err;
    logic               timeout;
    logic [2:0]         lsb3;
    logic [7:0]         strb_full;
    logic [SEL_W-1:0]   idx;
    logic [NUM_SLV-1:0] sel_dec;
    logic [AHB_DW-1:0]  prdata_sel;
    logic               pready_sel;
    logic               pslverr_sel;

    assign idx = addr_q[SLV_SEL_LSB +: SEL_W];

    apb_slv_mux #(
        .NUM_SLV (NUM_SLV),
        .AHB_DW  (AHB_DW)
    ) u_mux (
        .idx_i     (idx),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .pslverr_i (pslverr),
        .sel_o     (sel_dec),
        .prdata_o  (prdata_sel),
        .pready_o  (pready_sel),
        .pslverr_o (pslverr_sel)
    );

`ifdef AHB2APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;

    assign timeout = (state_q == ST_ACCESS) && !pready_sel && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_d == ST_SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign hreadyout = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign psel      = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? sel_dec : '0;
    assign penable   = (state_q == ST_ACCESS);
    assign paddr     = addr_q;
    assign pwrite    = write_q;
    assign pwdata    = wdata_q;
    assign pstrb     = strb_q;
    assign hrdata    = rdata_q;

    assign accept    = hsel && hready && hreadyout &&
                       (htrans_t'(htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
    assign lsb3      = 3'(addr_q[LSBW-1:0]);
    assign strb_full = strb_gen(size_q, lsb3);
    assign req_err   = (32'(idx) >= NUM_SLV) ||
                       (size_q > 3'(LSBW)) ||
                       ((lsb3 & ~(3'b111 << size_q)) != 3'b000);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: state_d = accept ? ST_LATCH : ST_IDLE;
            ST_LATCH:                  state_d = req_err ? ST_ERR1 : ST_SETUP;
            ST_SETUP:                  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_sel) begin
                    state_d = pslverr_sel ? ST_ERR1 : ST_DONE;
                end else if (timeout) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1:                   state_d = ST_ERR2;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= haddr;
                write_q <= hwrite;
                size_q  <= hsize;
            end
            if (state_q == ST_LATCH) begin
                wdata_q <= hwdata;
                strb_q  <= write_q ? strb_full[STRBW-1:0] : '0;
            end
            if ((state_q == ST_ACCESS) && pready_sel && !pslverr_sel && !write_q) begin
                rdata_q <= prdata_sel;
            end
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed self-checking bench for ahb2apb_bridge (cycle 0 = AHB address phase).
module tb_ahb2apb_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         hsel;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize;
    logic [31:0]  hwdata;
    logic         hready;
    logic         hreadyout;
    logic [31:0]  hrdata;
    logic         hresp;
    logic [31:0]  paddr;
    logic [3:0]   psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [127:0] prdata;
    logic [3:0]   pready;
    logic [3:0]   pslverr;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    ahb2apb_bridge #(
        .AHB_AW      (32),
        .AHB_DW      (32),
        .NUM_SLV     (4),
        .SLV_SEL_LSB (12),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hrdata    (hrdata),
        .hresp     (hresp),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    // Five-cycle zero-wait write; strobes checked in SETUP, OKAY checked in DONE.
    task automatic wr_strb(input string tag, input logic [31:0] a, input logic [2:0] s,
                           input logic [3:0] exp_strb);
        addr_phase(a, 1'b1, s);
        step();
        idle_bus();
        hwdata = 32'h0BAD_BEEF;
        step();
        chk({tag, "_pstrb"}, pstrb, exp_strb);
        step();
        step();
        chk({tag, "_done"}, {hreadyout, hresp}, 2'b10);
    endtask

    initial begin
        reset   = 1'b1;
        hsel    = 1'b0;
        haddr   = '0;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        hsize   = 3'd0;
        hwdata  = '0;
        hready  = 1'b1;
        prdata  = {32'h1234_5678, 32'hAAAA_0002, 32'hBBBB_0001, 32'hCCCC_0000};
        pready  = 4'b1111;
        pslverr = 4'b0000;
        step();
        step();
        chk("rst_hreadyout", hreadyout, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_psel", psel, 4'b0000);
        chk("rst_penable", penable, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pstrb", pstrb, 4'h0);
        chk("rst_hrdata", hrdata, 32'h0);
        reset = 1'b0;
        step();

        // IDLE and BUSY transfers: zero-wait OKAY, no APB activity
        hsel = 1'b1; htrans = 2'b00; haddr = 32'h1000;
        step();
        chk("idle_ready", {hreadyout, hresp, psel}, 6'b10_0000);
        htrans = 2'b01;
        step();
        chk("busy_ready", {hreadyout, hresp, psel}, 6'b10_0000);
        idle_bus();
        step();
        chk("busy_nopsel", psel, 4'b0000);

        // Zero-wait word write to slave 1
        addr_phase(32'h0000_1004, 1'b1, 3'd2);
        step();
        idle_bus();
        hwdata = 32'hCAFE_F00D;
        chk("w_latch_hready", hreadyout, 1'b0);
        step();
        chk("w_setup_psel", psel, 4'b0010);
        chk("w_setup_penable", penable, 1'b0);
        chk("w_setup_paddr", paddr, 32'h0000_1004);
        chk("w_setup_pstrb", pstrb, 4'hF);
        chk("w_setup_pwrite", pwrite, 1'b1);
        chk("w_setup_pwdata", pwdata, 32'hCAFE_F00D);
        step();
        chk("w_access", {psel, penable}, 5'b0010_1);
        chk("w_access_hready", hreadyout, 1'b0);
        step();
        chk("w_done", {hreadyout, hresp}, 2'b10);
        chk("w_done_psel", {psel, penable}, 5'b0000_0);
        chk("w_hrdata_kept", hrdata, 32'h0);

        wr_strb("byte3", 32'h0000_1003, 3'd0, 4'b1000);
        wr_strb("half2", 32'h0000_1002, 3'd1, 4'b1100);
        wr_strb("byte1", 32'h0000_2001, 3'd0, 4'b0010);

        // Read from slave 3 with three wait states
        pready = 4'b0111;
        addr_phase(32'h0000_3002, 1'b0, 3'd1);
        step();
        idle_bus();
        step();
        chk("r_setup_psel", psel, 4'b1000);
        chk("r_setup_pstrb", pstrb, 4'h0);
        chk("r_setup_pwrite", pwrite, 1'b0);
        chk("r_setup_paddr", paddr, 32'h0000_3002);
        step();
        chk("r_wait1", {hreadyout, penable, psel}, 6'b0_1_1000);
        step();
        step();
        chk("r_wait3", {hreadyout, penable, psel}, 6'b0_1_1000);
        step();
        pready = 4'b1111;
        chk("r_acc4_hready", hreadyout, 1'b0);
        step();
        chk("r_done", {hreadyout, hresp}, 2'b10);
        chk("r_hrdata", hrdata, 32'h1234_5678);
        chk("r_done_psel", psel, 4'b0000);
        step();

        // Out-of-range slave index
        addr_phase(32'h0000_5000, 1'b0, 3'd2);
        step();
        idle_bus();
        chk("dec_latch", {hreadyout, hresp}, 2'b00);
        step();
        chk("dec_err1", {hreadyout, hresp, psel}, 6'b01_0000);
        step();
        chk("dec_err2", {hreadyout, hresp, psel}, 6'b11_0000);
        step();
        chk("dec_idle", {hreadyout, hresp}, 2'b10);

        // Misaligned word and oversized transfer
        addr_phase(32'h0000_1002, 1'b0, 3'd2);
        step();
        idle_bus();
        step();
        chk("misalign_err1", {hreadyout, hresp, psel}, 6'b01_0000);
        step();
        step();
        addr_phase(32'h0000_1000, 1'b0, 3'd3);
        step();
        idle_bus();
        step();
        chk("oversize_err1", {hreadyout, hresp, psel}, 6'b01_0000);
        step();
        step();

        // PSLVERR on a write, back-to-back read accepted in ERR2
        pslverr = 4'b0100;
        addr_phase(32'h0000_2000, 1'b1, 3'd2);
        step();
        idle_bus();
        hwdata = 32'h1111_2222;
        step();
        chk("se_setup_psel", psel, 4'b0100);
        step();
        chk("se_access", penable, 1'b1);
        step();
        chk("se_err1", {hreadyout, hresp, psel, penable}, 7'b01_0000_0);
        step();
        chk("se_err2", {hreadyout, hresp}, 2'b11);
        chk("se_hrdata_kept", hrdata, 32'h1234_5678);
        addr_phase(32'h0000_0000, 1'b0, 3'd2);
        step();
        idle_bus();
        pslverr = 4'b0000;
        chk("b2b_latch", {hreadyout, hresp}, 2'b00);
        step();
        chk("b2b_setup_psel", psel, 4'b0001);
        step();
        step();
        chk("b2b_done", {hreadyout, hresp}, 2'b10);
        chk("b2b_hrdata", hrdata, 32'hCCCC_0000);
        step();

        // Reset in the middle of ACCESS
        pready = 4'b0000;
        addr_phase(32'h0000_1000, 1'b1, 3'd2);
        step();
        idle_bus();
        hwdata = 32'h55AA_55AA;
        step();
        step();
        chk("rma_access", {psel, penable}, 5'b0010_1);
        reset = 1'b1;
        step();
        chk("rma_psel", {psel, penable}, 5'b0000_0);
        chk("rma_resp", {hreadyout, hresp}, 2'b10);
        chk("rma_regs", {pstrb, pwdata}, 36'h0_0000_0000);
        chk("rma_hrdata", hrdata, 32'h0);
        reset = 1'b0;
        step();
        chk("rma_idle", {hreadyout, psel}, 5'b1_0000);

`ifdef AHB2APB_TIMEOUT_EN
        addr_phase(32'h0000_1000, 1'b0, 3'd2);
        step();
        idle_bus();
        step();
        for (int i = 0; i < 8; i++) step();
        chk("to_access8", {psel, penable}, 5'b0010_1);
        step();
        chk("to_err1", {hreadyout, hresp, psel, penable}, 7'b01_0000_0);
        step();
        chk("to_err2", {hreadyout, hresp}, 2'b11);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
